// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode control path.
// Holds the branch-kind encoding, the default reset and exception
// addresses, and the sequential PC increment.
package pipe_pkg;

  // Branch kinds resolved in D. Code 7 is reserved and acts as no branch.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PC_INC             = 32'd4;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator (pure combinational).
// Ports:
//   br_op     in  3   branch kind (pipe_pkg::br_op_t encoding)
//   rs, rt    in  32  operands, compared as signed where relevant
//   cond_true out 1   the selected condition holds
module branch_cmp
  import pipe_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        cond_true
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[31];
  assign rs_zero = (rs == 32'd0);

  always_comb begin
    cond_true = 1'b0;
    case (br_op_t'(br_op))
      BR_BEQ:  cond_true = (rs == rt);
      BR_BNE:  cond_true = (rs != rt);
      BR_BLEZ: cond_true = rs_neg | rs_zero;
      BR_BGTZ: cond_true = ~rs_neg & ~rs_zero;
      BR_BLTZ: cond_true = rs_neg;
      BR_BGEZ: cond_true = ~rs_neg;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-address generator: owns the F-stage PC, resolves D-stage control
// transfers (branches, j/jal, jr/jalr), exception entry and eret, tracks
// whether the fetched instruction is a delay slot, flags illegal fetch
// addresses and supplies the pc_d+8 link value.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   stall              freeze pc_f and bd_f (exc_req / eret still win)
//   valid_d            D holds a real instruction; gates every *_d control
//   pc_d, br_op_d, rs_d, rt_d, imm16_d, j_d, imm26_d, jr_d, eret_d
//                      D-stage instruction fields and forwarded operands
//   exc_req, epc       exception entry request, CP0 EPC for eret
//   pc_f, bd_f         fetch address and its delay-slot flag (registered)
//   adel_f             fetch address misaligned or outside instruction memory
//   taken_d            D control transfer redirects fetch
//   flush_f            kill the instruction in F (eret has no delay slot)
//   pc8_d              link value pc_d+8
module pc_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        valid_d,
  input  logic [31:0] pc_d,
  input  logic [2:0]  br_op_d,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  input  logic [15:0] imm16_d,
  input  logic        j_d,
  input  logic [25:0] imm26_d,
  input  logic        jr_d,
  input  logic        exc_req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic        bd_f,
  output logic        adel_f,
  output logic        taken_d,
  output logic        flush_f,
  output logic [31:0] pc8_d
);

  // End of the legal window, one bit wider so base+size cannot wrap.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

  logic        cond_true;
  logic        br_taken;
  logic        eret_ok;
  logic        is_ctrl;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] redirect_pc;

  branch_cmp u_branch_cmp (
    .br_op     (br_op_d),
    .rs        (rs_d),
    .rt        (rt_d),
    .cond_true (cond_true)
  );

  assign pc_d_plus4 = pc_d + PC_INC;
  assign br_target  = pc_d_plus4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
  assign j_target   = {pc_d_plus4[31:28], imm26_d, 2'b00};

  assign br_taken = valid_d & cond_true;
  assign eret_ok  = valid_d & eret_d;

  // Any control-transfer instruction in D makes the next fetch a delay slot,
  // taken or not. The reserved branch code is not a branch.
  assign is_ctrl = valid_d & (((br_op_d != BR_NONE) && (br_op_d != BR_RSVD)) | j_d | jr_d);

  // Unstalled, non-exceptional next PC; branch beats j beats jr.
  always_comb begin
    redirect_pc = pc_f + PC_INC;
    if (br_taken)            redirect_pc = br_target;
    else if (valid_d & j_d)  redirect_pc = j_target;
    else if (valid_d & jr_d) redirect_pc = rs_d;
  end

  // exc_req and eret redirect even while stalled; both clear the delay-slot flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
      bd_f <= 1'b0;
    end else if (exc_req) begin
      pc_f <= EXC_VECTOR;
      bd_f <= 1'b0;
    end else if (eret_ok) begin
      pc_f <= epc;
      bd_f <= 1'b0;
    end else if (!stall) begin
      pc_f <= redirect_pc;
      bd_f <= is_ctrl;
    end
  end

  assign taken_d = valid_d & (cond_true | j_d | jr_d);
  assign flush_f = eret_ok & ~exc_req;
  assign pc8_d   = pc_d + 32'd8;
  assign adel_f  = (pc_f[1:0] != 2'b00) | (pc_f < IMEM_BASE) | ({1'b0, pc_f} >= IMEM_END);

endmodule
